// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the fetch sequencer state type.
package cpu_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_INST_W = 16;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      REDIR,
      VALID
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: runs the instruction-memory handshake, owns PC advance and
// branch redirects, and buffers one instruction for the decode stage.
module if_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int INST_W = DEF_INST_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_addr,
   output logic              pc_en,
   output logic              br_taken,
   output logic [ADDR_W-1:0] br_addr,
   input  logic              ex_branch_req,
   input  logic [ADDR_W-1:0] ex_branch_addr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              id_valid,
   output logic [INST_W-1:0] id_inst,
   output logic [ADDR_W-1:0] id_pc,
   input  logic              id_ready,
   input  logic              stall,
   output logic [CNT_W-1:0]  fetch_cnt
);

   fetch_state_t      state;
   fetch_state_t      next_state;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] target_next;
   logic              id_fire;

   assign id_fire     = id_valid & id_ready & ~stall;
   // The most recent redirect always wins, including one arriving while draining.
   assign target_next = ex_branch_req ? ex_branch_addr : target;
   assign imem_addr   = pc_addr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = ex_branch_req ? REDIR : FETCH;
         FETCH: begin
            if (imem_ack) begin
               next_state = ex_branch_req ? REDIR : VALID;
            end else if (ex_branch_req) begin
               next_state = DRAIN;
            end
         end
         DRAIN:   next_state = imem_ack ? REDIR : DRAIN;
         REDIR:   next_state = ex_branch_req ? REDIR : FETCH;
         VALID: begin
            if (ex_branch_req) begin
               next_state = REDIR;
            end else if (id_fire) begin
               next_state = FETCH;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // PC may only move on the acknowledged cycle of an undisturbed fetch.
   always_comb begin
      imem_req = (state == FETCH) || (state == DRAIN);
      pc_en    = (state == FETCH) && imem_ack && !ex_branch_req;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         target    <= '0;
         br_taken  <= 1'b0;
         br_addr   <= '0;
         id_valid  <= 1'b0;
         id_inst   <= '0;
         id_pc     <= '0;
         fetch_cnt <= '0;
      end else begin
         target   <= target_next;
         br_taken <= (next_state == REDIR);
         if (next_state == REDIR) begin
            br_addr <= target_next;
         end
         if (pc_en) begin
            id_valid <= 1'b1;
            id_inst  <= imem_rdata;
            id_pc    <= pc_addr;
         end else if (id_fire || ex_branch_req) begin
            id_valid <= 1'b0;
         end
         if (id_fire) begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
         end
      end
   end

endmodule
